// File: rtl/pc_next_unit_pkg.sv
// pc_next_unit shared types and constants.
// State encoding and PC arithmetic constants.
package pc_next_unit_pkg;

  localparam int PC_WIDTH = 16;
  localparam logic [PC_WIDTH-1:0] PC_STEP = 16'd2;

  typedef enum logic [2:0] {
    BOOT   = 3'd0,
    FETCH  = 3'd1,
    WAIT   = 3'd2,
    HALTED = 3'd3,
    FAULT  = 3'd4
  } state_t;

endpackage

// File: rtl/pc_next_unit_if.sv
// pc_next_unit fetch/control bundle.
// slave: the PC unit; master: decode/imem side.
interface pc_next_unit_if;
  import pc_next_unit_pkg::*;

  logic                ImemReady;
  logic                Stall;
  logic                Branch;
  logic                Zero;
  logic [PC_WIDTH-1:0] BranchImm;
  logic                Jump;
  logic [11:0]         JumpAddr;
  logic                Halt;
  logic                ImemReq;
  logic [PC_WIDTH-1:0] PC;
  logic [PC_WIDTH-1:0] PCPlus2;
  logic                Running;
  logic                Fault;
  logic [PC_WIDTH-1:0] Retired;

  modport master (
    output ImemReady, Stall, Branch, Zero,
    output BranchImm, Jump, JumpAddr, Halt,
    input  ImemReq, PC, PCPlus2,
    input  Running, Fault, Retired
  );

  modport slave (
    input  ImemReady, Stall, Branch, Zero,
    input  BranchImm, Jump, JumpAddr, Halt,
    output ImemReq, PC, PCPlus2,
    output Running, Fault, Retired
  );

endinterface

// File: rtl/pc_next_unit_cla.sv
// 16-bit carry-lookahead adder.
// Four 4-bit lookahead groups, group carries chained.
module pc_next_unit_cla (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum
);

  logic [15:0] g;
  logic [15:0] p;
  logic [16:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // per-group lookahead carries; group carry feeds the next group
  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int k = 0; k < 16; k += 4) begin
      c[k+1] = g[k] | (p[k] & c[k]);
      c[k+2] = g[k+1] | (p[k+1] & g[k])
             | (p[k+1] & p[k] & c[k]);
      c[k+3] = g[k+2] | (p[k+2] & g[k+1])
             | (p[k+2] & p[k+1] & g[k])
             | (p[k+2] & p[k+1] & p[k] & c[k]);
      c[k+4] = g[k+3] | (p[k+3] & g[k+2])
             | (p[k+3] & p[k+2] & g[k+1])
             | (p[k+3] & p[k+2] & p[k+1] & g[k])
             | (p[k+3] & p[k+2] & p[k+1] & p[k] & c[k]);
    end
  end

  assign sum = p ^ c[15:0];

endmodule

// File: rtl/pc_next_unit.sv
// Program-counter stage: PC register, next-PC select,
// fetch sequencing, timeout watchdog, retire counter.
module pc_next_unit
  import pc_next_unit_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter int          TIMEOUT      = 8
) (
  input  logic           Clock,
  input  logic           Reset,
  pc_next_unit_if.slave  bus
);

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] ret_q, ret_d;
  logic [7:0]          wd_q, wd_d;
  logic [PC_WIDTH-1:0] pc_plus2;
  logic [PC_WIDTH-1:0] imm_sh;
  logic [PC_WIDTH-1:0] br_target;
  logic [PC_WIDTH-1:0] jmp_target;
  logic [PC_WIDTH-1:0] next_pc;

  assign imm_sh = bus.BranchImm << 1;

  pc_next_unit_cla u_inc (
    .a   (pc_q),
    .b   (PC_STEP),
    .cin (1'b0),
    .sum (pc_plus2)
  );

  pc_next_unit_cla u_br (
    .a   (pc_plus2),
    .b   (imm_sh),
    .cin (1'b0),
    .sum (br_target)
  );

  assign jmp_target = {pc_plus2[15:13], bus.JumpAddr, 1'b0};

  // next-PC priority: halt, jump, taken branch, sequential
  always_comb begin
    next_pc = pc_plus2;
    priority case (1'b1)
      bus.Halt:               next_pc = pc_q;
      bus.Jump:               next_pc = jmp_target;
      bus.Branch & bus.Zero:  next_pc = br_target;
      default:                next_pc = pc_plus2;
    endcase
  end

  // fetch FSM, PC/retire update and watchdog
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ret_d   = ret_q;
    wd_d    = wd_q;
    unique case (state_q)
      BOOT: state_d = FETCH;
      FETCH, WAIT: begin
        if (bus.ImemReady) begin
          wd_d    = '0;
          state_d = FETCH;
          if (!bus.Stall) begin
            ret_d = ret_q + 16'd1;
            if (bus.Halt) state_d = HALTED;
            else          pc_d    = next_pc;
          end
        end else begin
          wd_d    = (state_q == FETCH) ? 8'd1 : wd_q + 8'd1;
          state_d = (wd_d == 8'(TIMEOUT)) ? FAULT : WAIT;
        end
      end
      HALTED, FAULT: state_d = state_q;
      default: state_d = BOOT;
    endcase
  end

  // state registers with synchronous reset
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      ret_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ret_q   <= ret_d;
      wd_q    <= wd_d;
    end
  end

  assign bus.ImemReq = (state_q == FETCH) || (state_q == WAIT);
  assign bus.Running = (state_q == FETCH) || (state_q == WAIT);
  assign bus.Fault   = (state_q == FAULT);
  assign bus.PC      = pc_q;
  assign bus.PCPlus2 = pc_plus2;
  assign bus.Retired = ret_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit.
// Expected results queued per cycle, checked after the edge.
module tb_pc_next_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pc_next_unit_if bus ();

  pc_next_unit #(
    .RESET_VECTOR (16'h0000),
    .TIMEOUT      (8)
  ) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] pc2;
    logic [15:0] ret;
    logic        req;
    logic        run;
    logic        flt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ctl(input logic rdy, input logic stl,
                     input logic br, input logic zr,
                     input logic [15:0] imm,
                     input logic jmp, input logic [11:0] ja,
                     input logic hlt);
    bus.ImemReady = rdy;
    bus.Stall     = stl;
    bus.Branch    = br;
    bus.Zero      = zr;
    bus.BranchImm = imm;
    bus.Jump      = jmp;
    bus.JumpAddr  = ja;
    bus.Halt      = hlt;
  endtask

  task automatic step(input logic [15:0] pc,
                      input logic [15:0] ret,
                      input logic req, input logic run,
                      input logic flt);
    exp_t e;
    e.pc  = pc;
    e.pc2 = pc + 16'd2;
    e.ret = ret;
    e.req = req;
    e.run = run;
    e.flt = flt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: got empty expected entry");
    end else begin
      e = sb.pop_front();
      check("pc",      bus.PC, e.pc);
      check("pcplus2", bus.PCPlus2, e.pc2);
      check("retired", bus.Retired, e.ret);
      check("imemreq", {15'd0, bus.ImemReq}, {15'd0, e.req});
      check("running", {15'd0, bus.Running}, {15'd0, e.run});
      check("fault",   {15'd0, bus.Fault}, {15'd0, e.flt});
    end
  endtask

  initial begin
    ctl(1, 0, 0, 0, 16'h0, 0, 12'h0, 0);
    rst = 1'b1;
    step(16'h0000, 0, 0, 0, 0);
    rst = 1'b0;
    step(16'h0000, 0, 1, 1, 0);
    step(16'h0002, 1, 1, 1, 0);
    step(16'h0004, 2, 1, 1, 0);
    step(16'h0006, 3, 1, 1, 0);

    ctl(1, 0, 0, 0, 16'h0, 1, 12'h008, 0);
    step(16'h0010, 4, 1, 1, 0);
    ctl(1, 0, 1, 1, 16'hFFFC, 0, 12'h0, 0);
    step(16'h000A, 5, 1, 1, 0);
    ctl(1, 0, 0, 0, 16'h0, 1, 12'h008, 0);
    step(16'h0010, 6, 1, 1, 0);
    ctl(1, 0, 1, 0, 16'hFFFC, 0, 12'h0, 0);
    step(16'h0012, 7, 1, 1, 0);
    ctl(1, 0, 1, 1, 16'h0FF8, 0, 12'h0, 0);
    step(16'h2004, 8, 1, 1, 0);
    ctl(1, 0, 1, 1, 16'h0FF8, 1, 12'h123, 0);
    step(16'h2246, 9, 1, 1, 0);
    ctl(1, 0, 1, 1, 16'h6EDB, 0, 12'h0, 0);
    step(16'hFFFE, 10, 1, 1, 0);
    ctl(1, 0, 0, 0, 16'h0, 0, 12'h0, 0);
    step(16'h0000, 11, 1, 1, 0);

    ctl(1, 1, 0, 0, 16'h0, 0, 12'h0, 0);
    for (int i = 0; i < 3; i++) step(16'h0000, 11, 1, 1, 0);
    ctl(1, 1, 0, 0, 16'h0, 0, 12'h0, 1);
    step(16'h0000, 11, 1, 1, 0);

    ctl(1, 0, 0, 0, 16'h0, 1, 12'h020, 0);
    step(16'h0040, 12, 1, 1, 0);
    ctl(0, 0, 0, 0, 16'h0, 0, 12'h0, 0);
    for (int i = 0; i < 3; i++) step(16'h0040, 12, 1, 1, 0);
    ctl(1, 0, 0, 0, 16'h0, 0, 12'h0, 0);
    step(16'h0042, 13, 1, 1, 0);

    ctl(0, 0, 0, 0, 16'h0, 1, 12'h0FF, 0);
    for (int i = 0; i < 7; i++) step(16'h0042, 13, 1, 1, 0);
    step(16'h0042, 13, 0, 0, 1);
    ctl(1, 0, 1, 1, 16'h0010, 1, 12'h0FF, 0);
    for (int i = 0; i < 2; i++) step(16'h0042, 13, 0, 0, 1);

    rst = 1'b1;
    step(16'h0000, 0, 0, 0, 0);
    rst = 1'b0;
    ctl(1, 0, 0, 0, 16'h0, 0, 12'h0, 0);
    step(16'h0000, 0, 1, 1, 0);
    ctl(1, 0, 0, 0, 16'h0, 1, 12'h020, 0);
    step(16'h0040, 1, 1, 1, 0);
    ctl(1, 0, 0, 0, 16'h0, 0, 12'h0, 1);
    step(16'h0040, 2, 0, 0, 0);
    ctl(1, 0, 1, 1, 16'h0010, 1, 12'h555, 0);
    for (int i = 0; i < 2; i++) step(16'h0040, 2, 0, 0, 0);
    ctl(0, 0, 0, 0, 16'h0, 0, 12'h0, 0);
    for (int i = 0; i < 10; i++) step(16'h0040, 2, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Program-counter stage of the single-cycle processor: holds the 16-bit PC, computes PC+2, branch and jump targets, and sequences instruction fetch with the instruction memory.
- The PC+2 and branch-target additions use the team's 16-bit CLA adder. This block is the register/control stage that consumes those sums and feeds the instruction memory address.
- It adds a fetch handshake, stall hold, halt, a fetch-timeout watchdog and a retired-instruction counter.

Parameters:
- RESET_VECTOR, 16'h0000, PC value loaded on reset.
- TIMEOUT, 8, maximum consecutive cycles waiting on ImemReady before entering FAULT (range 1..255).

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- ImemReady  in  1  instruction memory has returned the word addressed by PC this cycle.
- Stall  in  1  hazard hold; PC must not advance.
- Branch  in  1  current instruction is a conditional branch.
- Zero  in  1  ALU zero flag; branch taken when Branch & Zero.
- BranchImm  in  16  sign-extended word offset.
- Jump  in  1  current instruction is an absolute jump.
- JumpAddr  in  12  jump word address.
- Halt  in  1  current instruction is HALT.
- ImemReq  out  1  fetch request for address PC.
- PC  out  16  current program counter.
- PCPlus2  out  16  PC + 2 (combinational).
- Running  out  1  high in FETCH or WAIT.
- Fault  out  1  sticky fetch-timeout flag.
- Retired  out  16  count of instructions retired since reset.

Behaviour:
- All state changes occur on the rising edge of Clock. Reset is synchronous, active-high and overrides everything, including mid-WAIT or FAULT.
- Values on reset:
  - PC = RESET_VECTOR
  - state = BOOT
  - ImemReq = 0, Running = 0, Fault = 0, Retired = 0
  - watchdog counter = 0
- Arithmetic, all modulo 2^16 with wrap-around and no overflow flag:
  - PCPlus2 = PC + 16'd2 (adder CIN = 0).
  - BranchTarget = PCPlus2 + (BranchImm << 1); bits shifted out above bit 15 are discarded.
  - JumpTarget = {PCPlus2[15:13], JumpAddr, 1'b0}.
- NextPC priority:
  1. Halt: PC holds.
  2. Jump: JumpTarget.
  3. Branch & Zero: BranchTarget.
  4. Otherwise: PCPlus2.
- States:
  - BOOT: ImemReq = 0. Unconditionally moves to FETCH after one cycle, so the first fetch is at RESET_VECTOR in the second cycle after Reset deasserts.
  - FETCH: ImemReq = 1.
    - ImemReady & Halt: PC holds, Retired += 1, go to HALTED.
    - ImemReady & !Stall & !Halt: PC <= NextPC, Retired += 1, stay in FETCH (one instruction per cycle).
    - ImemReady & Stall: PC holds, Retired unchanged, stay in FETCH. The watchdog does not count stall cycles.
    - !ImemReady: go to WAIT, watchdog = 1.
  - WAIT: ImemReq = 1, PC holds.
    - ImemReady: apply the same rules as FETCH in that cycle, reset the watchdog to 0, and go to FETCH, or to HALTED on Halt.
    - Otherwise watchdog += 1. When watchdog reaches TIMEOUT with ImemReady still low, go to FAULT.
  - HALTED: ImemReq = 0, Running = 0, PC frozen at the HALT address. All inputs are ignored; only Reset exits.
  - FAULT: Fault = 1, ImemReq = 0, Running = 0, PC frozen. Only Reset exits.
- Simultaneous events:
  - Halt and Stall both asserted: Halt wins only when Stall is low. A stalled HALT is held like any other instruction.
  - Jump and Branch & Zero both asserted: Jump wins.
- Retired wraps from 16'hFFFF to 16'h0000 silently.
- Branch, Jump and Halt are sampled only in a cycle where ImemReady = 1. They are don't-care otherwise.

Decomposition:
- Shared package holds:
  - state encoding: BOOT = 3'd0, FETCH = 3'd1, WAIT = 3'd2, HALTED = 3'd3, FAULT = 3'd4
  - PC_WIDTH = 16
  - PC_STEP = 16'd2
- Sub-module: two instances of the existing 16-bit CLA adder, one for PC+2 and one for the branch target. No new sub-module is written.

Test Plan:
- Reset, then ImemReady held at 1 with no control inputs for 4 cycles: PC sequence 0000, 0000 (BOOT), 0002, 0004, 0006; Retired = 3.
- At PC = 0010, Branch = 1, Zero = 1, BranchImm = 16'hFFFC: next PC = 000A. Repeat with Zero = 0: next PC = 0012.
- At PC = 2004, Jump = 1, Branch = 1, Zero = 1, JumpAddr = 12'h123: next PC = 2246, confirming Jump priority.
- PC = FFFE sequential step: PC wraps to 0000. Separately, Stall held for 3 cycles: PC and Retired unchanged, Fault stays 0.
- ImemReady low for TIMEOUT = 8 cycles: Fault = 1, ImemReq = 0. Assert Reset mid-fault: all outputs return to reset values on the next edge.
- Halt with ImemReady = 1 at PC = 0040: state HALTED, PC stays 0040, Running = 0. Further Jump or Branch inputs are ignored.
